isqrt_8bit_seq: RTL and testbench

Sequential integer square-root unit, the inverse of the team's 4-bit combinational squarer. Accepts an unsigned N-bit operand over a valid/ready handshake, computes floor(sqrt(x)) and the remainder by a restoring digit-by-digit method at one root bit per cycle, and returns both over a second valid/ready handshake. It sits beside the squarer in the arithmetic library; the bench uses the squarer as its checker (root² + rem == x).

---
 rtl/isqrt_pkg.sv | 16 +
 rtl/isqrt_step.sv | 26 ++
 rtl/isqrt_8bit_seq.sv | 98 +++++++++
 tb/tb_isqrt_8bit_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/isqrt_pkg.sv
// Shared types and default widths for the sequential integer square-root unit.
// The width constants carry a DEF_ prefix so they never collide with a module's own N parameter.
package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N    = 8;
  localparam int DEF_RW   = DEF_N / 2;
  localparam int DEF_REMW = DEF_N / 2 + 1;
  localparam int DEF_WW   = DEF_N / 2 + 2;

endpackage

// File: rtl/isqrt_step.sv
// One restoring iteration: brings in the next operand bit-pair and decides the next root bit.
module isqrt_step #(
  parameter int RW = 4
) (
  input  logic [RW+1:0] rem_w,
  input  logic [1:0]    pair,
  input  logic [RW-1:0] root,
  output logic [RW+1:0] rem_next,
  output logic          root_bit
);

  localparam int WW = RW + 2;

  logic [WW+1:0] cand;
  logic [WW+1:0] trial;

  // Compare at full width so the borrow is never lost. The accepted difference
  // always fits in WW bits because rem <= 2*root holds before every step.
  always_comb begin
    cand     = {rem_w, pair};
    trial    = {2'b00, root, 2'b01};
    root_bit = (cand >= trial);
    rem_next = root_bit ? (cand[WW-1:0] - trial[WW-1:0]) : cand[WW-1:0];
  end

endmodule

// File: rtl/isqrt_8bit_seq.sv
// Sequential floor(sqrt(x)) with remainder; one root bit per cycle.
// Operands arrive and results leave over valid/ready handshakes.
module isqrt_8bit_seq
  import isqrt_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   x,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N/2-1:0] root,
  output logic [N/2:0]   rem
);

  localparam int RW   = N / 2;
  localparam int REMW = RW + 1;
  localparam int WW   = RW + 2;
  localparam int CW   = $clog2(RW + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  op_q, op_d;
  logic [WW-1:0] rem_q, rem_d;
  logic [RW-1:0] root_q, root_d;

  logic [WW-1:0] step_rem;
  logic          step_bit;

  isqrt_step #(.RW(RW)) u_step (
    .rem_w    (rem_q),
    .pair     (op_q[N-1:N-2]),
    .root     (root_q),
    .rem_next (step_rem),
    .root_bit (step_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      root_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rem_d   = rem_q;
    root_d  = root_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = x;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = CW'(RW - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d  = step_rem;
        root_d = (root_q << 1) | RW'(step_bit);
        op_d   = op_q << 2;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        // A result is taken and a new operand accepted on separate cycles.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign root      = root_q;
  assign rem       = rem_q[REMW-1:0];

endmodule

// File: tb/tb_isqrt_8bit_seq.sv
// Self-checking bench for isqrt_8bit_seq: directed cases, exhaustive sweep and random stalls
// against a cycle-level behavioural model.
module tb_isqrt_8bit_seq;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] root;
  logic [4:0] rem;

  int n_checks = 0;
  int n_fail   = 0;

  isqrt_8bit_seq #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .root      (root),
    .rem       (rem)
  );

  always #5 clk = ~clk;

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Behavioural stand-in for the 4-bit combinational squarer.
  function automatic int sq4(input logic [3:0] a);
    return int'(a) * int'(a);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase of the unit plus the result it must present.
  typedef enum {M_IDLE, M_BUSY, M_DONE} mph_t;
  mph_t m_ph;
  int   m_age;
  int   m_x;
  int   m_root;
  int   m_rem;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph   = M_IDLE;
      m_age  = 0;
      m_root = 0;
      m_rem  = 0;
    end else begin
      case (m_ph)
        M_IDLE: if (in_valid) begin
          m_ph  = M_BUSY;
          m_x   = int'(x);
          m_age = 0;
        end
        M_BUSY: begin
          m_age++;
          if (m_age == LAT) begin
            m_ph   = M_DONE;
            m_root = isqrt(m_x);
            m_rem  = m_x - m_root * m_root;
          end
        end
        M_DONE: if (out_ready) m_ph = M_IDLE;
        default: m_ph = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("mon_in_ready", int'(in_ready), int'(m_ph == M_IDLE));
      chk("mon_out_valid", int'(out_valid), int'(m_ph == M_DONE));
      if (m_ph != M_BUSY) begin
        chk("mon_root", int'(root), m_root);
        chk("mon_rem", int'(rem), m_rem);
      end
    end
  end

  task automatic run_op(input int xv, input int stall, input int er, input int erem, input bit poke);
    int lat;
    int r0;
    int m0;
    chk("accept_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    x        = 8'(xv);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x        = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, LAT);
    r0 = int'(root);
    m0 = int'(rem);
    chk("rem_le_2root", int'(m0 <= 2 * r0), 1);
    chk("sq_plus_rem", sq4(root) + m0, xv);
    if (er >= 0) begin
      chk("root_lit", r0, er);
      chk("rem_lit", m0, erem);
    end
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        in_valid = 1'b1;
        x        = 8'd9;
      end
      @(posedge clk); #1;
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_root", int'(root), r0);
      chk("hold_rem", int'(rem), m0);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("take_valid", int'(out_valid), 0);
    chk("take_ready", int'(in_ready), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = 8'd0;
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_root", int'(root), 0);
    chk("rst_rem", int'(rem), 0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    run_op(144, 0, 12, 0, 1'b0);
    run_op(255, 0, 15, 30, 1'b0);
    run_op(0, 0, 0, 0, 1'b0);
    run_op(15, 0, 3, 6, 1'b0);
    run_op(200, 10, 14, 4, 1'b1);
    run_op(9, 0, 3, 0, 1'b0);

    // Reset two cycles into CALC; outputs must clear with no clock edge.
    in_valid = 1'b1;
    x        = 8'd100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_root", int'(root), 0);
    chk("arst_rem", int'(rem), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_op(100, 0, 10, 0, 1'b0);

    for (int v = 0; v < 256; v++) begin
      run_op(v, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, -1, 0, 1'b0);
    end

    for (int k = 0; k < 20; k++) begin
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 5)), -1, 0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
